adc_readout_sequencer: RTL

ADC_READOUT_SEQUENCER -- requirements
Module: adc_readout_sequencer

---
 rtl/adc_readout_sequencer_if.sv | 32 +++
 rtl/adc_readout_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_readout_sequencer_if.sv
// ADC readout sequencer bus bundle.
// Groups the ADC controller handshake, the ADC FIFO controls and the pixel
// output stream. The sequencer uses the master modport; the ADC/FIFO side
// and any pixel consumer use the slave modport.
interface adc_readout_sequencer_if;
    // ADC controller handshake
    logic        adc_start;
    logic        adc_busy;
    logic        adc_data_valid;
    logic [13:0] adc_data_reg;
    // ADC FIFO
    logic [10:0] fifo_level;
    logic        fifo_rd;
    logic        fifo_flush;
    // Pixel output stream
    logic        pix_valid;
    logic [13:0] pix_data;
    logic        pix_sof;
    logic        pix_eol;

    modport master (
        output adc_start, fifo_rd, fifo_flush,
        output pix_valid, pix_data, pix_sof, pix_eol,
        input  adc_busy, adc_data_valid, adc_data_reg, fifo_level
    );

    modport slave (
        input  adc_start, fifo_rd, fifo_flush,
        input  pix_valid, pix_data, pix_sof, pix_eol,
        output adc_busy, adc_data_valid, adc_data_reg, fifo_level
    );
endinterface

// File: rtl/adc_readout_sequencer.sv
// ADC readout sequencer.
// Walks a ROWS x COLS frame one conversion at a time: requests a conversion,
// follows the ADC busy handshake, forwards the returned sample as a pixel
// (with start-of-frame / end-of-line flags) and pops it from the ADC FIFO.
// New conversions stall while the FIFO is at or above LEVEL_HI.
// Optional feature macro: ADC_SEQ_ROW_GAP_EN -- when defined the inter-row
// GAP state lasts ROW_GAP cycles; otherwise it lasts a single cycle.
module adc_readout_sequencer #(
    parameter int COLS     = 64,
    parameter int ROWS     = 32,
    parameter int LEVEL_HI = 2040,
    parameter int ROW_GAP  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           frame_start,
    input  logic                           abort,
    adc_readout_sequencer_if.master        bus,
    output logic [7:0]                     row_idx,
    output logic [7:0]                     col_idx,
    output logic                           seq_busy,
    output logic                           frame_done,
    output logic                           err_drop
);

    // Elaboration-time guard on the supported parameter ranges.
    if (COLS < 2 || COLS > 256 || ROWS < 1 || ROWS > 256 ||
        ROW_GAP < 1 || ROW_GAP > 255) begin : g_param_check
        $error("adc_readout_sequencer: parameter out of range");
    end

    localparam logic [7:0]  COL_MAX = 8'(COLS - 1);
    localparam logic [7:0]  ROW_MAX = 8'(ROWS - 1);
    localparam logic [11:0] LVL_HI  = 12'(LEVEL_HI);
`ifdef ADC_SEQ_ROW_GAP_EN
    localparam logic [7:0]  GAP_LAST = 8'(ROW_GAP - 1);
`endif

    typedef enum logic [3:0] {
        IDLE, FLUSH, START, WAIT_BUSY, WAIT_DONE, NEXT, GAP, ABORT, DONE
    } state_t;

    state_t      state_q;
    logic [7:0]  row_q;
    logic [7:0]  col_q;
    logic [1:0]  wait_cnt_q;   // cycles spent in WAIT_BUSY without busy
    logic        got_q;        // current conversion already delivered a sample
`ifdef ADC_SEQ_ROW_GAP_EN
    logic [7:0]  gap_cnt_q;
`endif
    logic        adc_start_q;
    logic        fifo_rd_q;
    logic        fifo_flush_q;
    logic        pix_valid_q;
    logic [13:0] pix_data_q;
    logic        pix_sof_q;
    logic        pix_eol_q;
    logic        seq_busy_q;
    logic        frame_done_q;
    logic        err_drop_q;

    logic        take_sample;
    logic        fifo_stall;

    // Sample is accepted only in the capture window, and only once per conversion.
    always_comb begin
        take_sample = bus.adc_data_valid && !got_q &&
                      (state_q == WAIT_DONE || state_q == NEXT);
        fifo_stall  = ({1'b0, bus.fifo_level} >= LVL_HI);
    end

    // Sequencer FSM with registered control, counters and pixel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            wait_cnt_q   <= '0;
            got_q        <= 1'b0;
`ifdef ADC_SEQ_ROW_GAP_EN
            gap_cnt_q    <= '0;
`endif
            adc_start_q  <= 1'b0;
            fifo_rd_q    <= 1'b0;
            fifo_flush_q <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= '0;
            pix_sof_q    <= 1'b0;
            pix_eol_q    <= 1'b0;
            seq_busy_q   <= 1'b0;
            frame_done_q <= 1'b0;
            err_drop_q   <= 1'b0;
        end else begin
            // Single-cycle strobes default low.
            adc_start_q  <= 1'b0;
            fifo_rd_q    <= 1'b0;
            fifo_flush_q <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_sof_q    <= 1'b0;
            pix_eol_q    <= 1'b0;
            frame_done_q <= 1'b0;

            if (abort && state_q != IDLE && state_q != ABORT) begin
                // Abort wins over everything: no conversion request, no capture.
                state_q <= ABORT;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (frame_start) begin
                            row_q        <= '0;
                            col_q        <= '0;
                            err_drop_q   <= 1'b0;
                            fifo_flush_q <= 1'b1;
                            seq_busy_q   <= 1'b1;
                            state_q      <= FLUSH;
                        end
                    end
                    FLUSH: state_q <= START;
                    START: begin
                        if (!fifo_stall) begin
                            adc_start_q <= 1'b1;
                            wait_cnt_q  <= '0;
                            got_q       <= 1'b0;
                            state_q     <= WAIT_BUSY;
                        end
                    end
                    WAIT_BUSY: begin
                        if (bus.adc_busy) begin
                            state_q <= WAIT_DONE;
                        end else if (wait_cnt_q == 2'd3) begin
                            // ADC never acknowledged: give up on this conversion.
                            err_drop_q <= 1'b1;
                            state_q    <= NEXT;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 2'd1;
                        end
                    end
                    WAIT_DONE: begin
                        if (!bus.adc_busy) state_q <= NEXT;
                    end
                    NEXT: begin
                        if (!got_q && !bus.adc_data_valid) err_drop_q <= 1'b1;
                        if (col_q < COL_MAX) begin
                            col_q   <= col_q + 8'd1;
                            state_q <= START;
                        end else if (row_q < ROW_MAX) begin
                            col_q   <= '0;
                            row_q   <= row_q + 8'd1;
`ifdef ADC_SEQ_ROW_GAP_EN
                            gap_cnt_q <= '0;
`endif
                            state_q <= GAP;
                        end else begin
                            // Last pixel of the frame: indices hold their final values.
                            frame_done_q <= 1'b1;
                            state_q      <= DONE;
                        end
                    end
                    GAP: begin
`ifdef ADC_SEQ_ROW_GAP_EN
                        if (gap_cnt_q == GAP_LAST) begin
                            state_q <= START;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 8'd1;
                        end
`else
                        state_q <= START;
`endif
                    end
                    ABORT: begin
                        // Let the in-flight conversion finish before flushing.
                        if (!bus.adc_busy) begin
                            fifo_flush_q <= 1'b1;
                            seq_busy_q   <= 1'b0;
                            state_q      <= IDLE;
                        end
                    end
                    DONE: begin
                        seq_busy_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                    default: begin
                        seq_busy_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                endcase

                if (take_sample) begin
                    got_q       <= 1'b1;
                    pix_valid_q <= 1'b1;
                    fifo_rd_q   <= 1'b1;
                    pix_data_q  <= bus.adc_data_reg;
                    pix_sof_q   <= (row_q == 8'd0) && (col_q == 8'd0);
                    pix_eol_q   <= (col_q == COL_MAX);
                end
            end
        end
    end

    assign bus.adc_start  = adc_start_q;
    assign bus.fifo_rd    = fifo_rd_q;
    assign bus.fifo_flush = fifo_flush_q;
    assign bus.pix_valid  = pix_valid_q;
    assign bus.pix_data   = pix_data_q;
    assign bus.pix_sof    = pix_sof_q;
    assign bus.pix_eol    = pix_eol_q;
    assign row_idx        = row_q;
    assign col_idx        = col_q;
    assign seq_busy       = seq_busy_q;
    assign frame_done     = frame_done_q;
    assign err_drop       = err_drop_q;

endmodule
